// File: rtl/regfile_pclr_if.sv
// Bus bundle for regfile_pclr: one write port, two read ports and the clear-busy flag.
// The master drives writes and read addresses; the slave (the register file) returns data.
interface regfile_pclr_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              w_en_rf_i;
    logic [ADDR_W-1:0] w_reg_rf_i;
    logic [DATA_W-1:0] w_data_rf_i;
    logic [ADDR_W-1:0] r_reg_p1_rf_i;
    logic [ADDR_W-1:0] r_reg_p2_rf_i;
    logic [DATA_W-1:0] r_data_p1_rf_o;
    logic [DATA_W-1:0] r_data_p2_rf_o;
    logic              clr_busy_rf_o;

    modport master (
        output w_en_rf_i,
        output w_reg_rf_i,
        output w_data_rf_i,
        output r_reg_p1_rf_i,
        output r_reg_p2_rf_i,
        input  r_data_p1_rf_o,
        input  r_data_p2_rf_o,
        input  clr_busy_rf_o
    );

    modport slave (
        input  w_en_rf_i,
        input  w_reg_rf_i,
        input  w_data_rf_i,
        input  r_reg_p1_rf_i,
        input  r_reg_p2_rf_i,
        output r_data_p1_rf_o,
        output r_data_p2_rf_o,
        output clr_busy_rf_o
    );
endinterface

// File: rtl/regfile_pclr.sv
// Decode-stage register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero entry 0, optional write-to-read bypass, and a reset-driven clear sequencer.
module regfile_pclr #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 5,
    parameter bit                ZERO_REG = 1'b1,
    parameter bit                BYPASS   = 1'b1,
    parameter logic [DATA_W-1:0] CLR_VAL  = {DATA_W{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    regfile_pclr_if.slave rf
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [ADDR_W-1:0] clr_ptr_d;
    logic              busy_q;
    logic              busy_d;
    logic              last_entry_s;
    logic              clr_we_s;
    logic              wr_commit_s;
    logic              w_zero_s;
    logic              zero_p1_s;
    logic              zero_p2_s;
    logic              byp_p1_s;
    logic              byp_p2_s;
    logic [DATA_W-1:0] rd_p1_s;
    logic [DATA_W-1:0] rd_p2_s;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Read-port priority: clear in progress, then hardwired zero, then bypass, then stored data.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic              busy,
        input logic              zero_hit,
        input logic              byp_hit,
        input logic [DATA_W-1:0] w_data,
        input logic [DATA_W-1:0] arr_data
    );
        logic [DATA_W-1:0] res;
        if (busy) begin
            res = CLR_VAL;
        end else if (zero_hit) begin
            res = {DATA_W{1'b0}};
        end else if (byp_hit) begin
            res = w_data;
        end else begin
            res = arr_data;
        end
        return res;
    endfunction

    assign last_entry_s = (clr_ptr_q == ADDR_W'(DEPTH - 1));
    assign w_zero_s     = ZERO_REG && (rf.w_reg_rf_i == {ADDR_W{1'b0}});

    // State register: reset parks the sequencer at entry 0 with busy raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= {ADDR_W{1'b0}};
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic: walk the pointer across every entry, then return to idle.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                state_d   = ST_IDLE;
                clr_ptr_d = {ADDR_W{1'b0}};
            end
            ST_CLEAR: begin
                if (last_entry_s) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Output decode: array write strobes and the next value of the registered busy flag.
    always_comb begin
        busy_d      = (state_d == ST_CLEAR);
        clr_we_s    = (state_q == ST_CLEAR) && !reset;
        wr_commit_s = rf.w_en_rf_i && (state_q == ST_IDLE) && !reset && !w_zero_s;
    end

    // Storage array; intentionally not reset, the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_q[clr_ptr_q] <= CLR_VAL;
        end else if (wr_commit_s) begin
            mem_q[rf.w_reg_rf_i] <= rf.w_data_rf_i;
        end
    end

    // Per-port hit detection for the zero entry and the same-cycle bypass.
    always_comb begin
        zero_p1_s = ZERO_REG && (rf.r_reg_p1_rf_i == {ADDR_W{1'b0}});
        zero_p2_s = ZERO_REG && (rf.r_reg_p2_rf_i == {ADDR_W{1'b0}});
        byp_p1_s  = BYPASS && wr_commit_s && (rf.w_reg_rf_i == rf.r_reg_p1_rf_i);
        byp_p2_s  = BYPASS && wr_commit_s && (rf.w_reg_rf_i == rf.r_reg_p2_rf_i);
    end

    // Combinational read ports.
    always_comb begin
        rd_p1_s = rd_sel(busy_q, zero_p1_s, byp_p1_s, rf.w_data_rf_i, mem_q[rf.r_reg_p1_rf_i]);
        rd_p2_s = rd_sel(busy_q, zero_p2_s, byp_p2_s, rf.w_data_rf_i, mem_q[rf.r_reg_p2_rf_i]);
    end

    assign rf.r_data_p1_rf_o = rd_p1_s;
    assign rf.r_data_p2_rf_o = rd_p2_s;
    assign rf.clr_busy_rf_o  = busy_q;
endmodule

// File: tb/tb_regfile_pclr.sv
// Bench for regfile_pclr: three instances (32x32 zero+bypass, 32x32 plain, 8x64 zero+bypass)
// share one stimulus stream; a reference model pushes expected reads to a scoreboard queue.
module tb_regfile_pclr;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        w_en;
    logic [4:0]  w_reg;
    logic [63:0] w_data;
    logic [4:0]  ra1;
    logic [4:0]  ra2;

    localparam logic [63:0] CLR_A = 64'h0000_0000_5A5A_0F0F;
    localparam logic [63:0] CLR_B = 64'h0000_0000_C1C1_C1C1;
    localparam logic [63:0] CLR_C = 64'h0123_4567_89AB_CDEF;

    regfile_pclr_if #(.DATA_W(32), .ADDR_W(5)) if_a ();
    regfile_pclr_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
    regfile_pclr_if #(.DATA_W(64), .ADDR_W(3)) if_c ();

    assign if_a.w_en_rf_i     = w_en;
    assign if_a.w_reg_rf_i    = w_reg;
    assign if_a.w_data_rf_i   = w_data[31:0];
    assign if_a.r_reg_p1_rf_i = ra1;
    assign if_a.r_reg_p2_rf_i = ra2;
    assign if_b.w_en_rf_i     = w_en;
    assign if_b.w_reg_rf_i    = w_reg;
    assign if_b.w_data_rf_i   = w_data[31:0];
    assign if_b.r_reg_p1_rf_i = ra1;
    assign if_b.r_reg_p2_rf_i = ra2;
    assign if_c.w_en_rf_i     = w_en;
    assign if_c.w_reg_rf_i    = w_reg[2:0];
    assign if_c.w_data_rf_i   = w_data;
    assign if_c.r_reg_p1_rf_i = ra1[2:0];
    assign if_c.r_reg_p2_rf_i = ra2[2:0];

    regfile_pclr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLR_VAL(CLR_A[31:0]))
        dut_a (.clk(clk), .reset(reset), .rf(if_a));
    regfile_pclr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0), .CLR_VAL(CLR_B[31:0]))
        dut_b (.clk(clk), .reset(reset), .rf(if_b));
    regfile_pclr #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1), .CLR_VAL(CLR_C))
        dut_c (.clk(clk), .reset(reset), .rf(if_c));

    int checks   = 0;
    int failures = 0;

    int          depth [3] = '{32, 32, 8};
    bit          zr    [3] = '{1'b1, 1'b0, 1'b1};
    bit          bp    [3] = '{1'b1, 1'b0, 1'b1};
    logic [63:0] clrv  [3] = '{CLR_A, CLR_B, CLR_C};
    logic [63:0] mask  [3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] m_mem [3][32];
    bit          m_busy [3];
    int          m_ptr  [3];
    logic [63:0] exp_q [$];
    int          cnt [3];

    function automatic logic [4:0] amask(int k, logic [4:0] a);
        return a & 5'(depth[k] - 1);
    endfunction

    function automatic bit m_commit(int k);
        return w_en && !m_busy[k] && !reset && !(zr[k] && amask(k, w_reg) == 5'd0);
    endfunction

    function automatic logic [63:0] m_read(int k, logic [4:0] a);
        logic [4:0] aa;
        aa = amask(k, a);
        if (m_busy[k]) return clrv[k];
        else if (zr[k] && aa == 5'd0) return 64'd0;
        else if (bp[k] && m_commit(k) && amask(k, w_reg) == aa) return w_data & mask[k];
        else return m_mem[k][aa];
    endfunction

    function automatic logic [63:0] act(int i);
        case (i)
            0: return {32'd0, if_a.r_data_p1_rf_o};
            1: return {32'd0, if_a.r_data_p2_rf_o};
            2: return {32'd0, if_b.r_data_p1_rf_o};
            3: return {32'd0, if_b.r_data_p2_rf_o};
            4: return if_c.r_data_p1_rf_o;
            5: return if_c.r_data_p2_rf_o;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic act_busy(int k);
        case (k)
            0: return if_a.clr_busy_rf_o;
            1: return if_b.clr_busy_rf_o;
            2: return if_c.clr_busy_rf_o;
            default: return 1'bx;
        endcase
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_busy[k] = 1'b1;
                m_ptr[k]  = 0;
            end else if (m_busy[k]) begin
                m_mem[k][m_ptr[k]] = clrv[k];
                if (m_ptr[k] == depth[k] - 1) begin
                    m_busy[k] = 1'b0;
                    m_ptr[k]  = 0;
                end else begin
                    m_ptr[k]++;
                end
            end else if (m_commit(k)) begin
                m_mem[k][amask(k, w_reg)] = w_data & mask[k];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Drives one cycle of stimulus and pushes the six expected read values.
    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        w_en   = we;
        w_reg  = wa;
        w_data = wd;
        ra1    = a1;
        ra2    = a2;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(m_read(k, a1));
            exp_q.push_back(m_read(k, a2));
        end
    endtask

    task automatic test_reset();
        logic [63:0] e, g;
        reset = 1'b1;
        w_en = 1'b1; w_reg = 5'd3; w_data = 64'h77; ra1 = 5'd3; ra2 = 5'd0;
        repeat (3) tick();
        drive(1'b1, 5'd3, 64'h77, 5'd3, 5'd0);
        #1;
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front(); g = act(i); checks++;
            if (g !== e) begin failures++; $display("FAIL reset_read[%0d] got=%h exp=%h", i, g, e); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act_busy(k) !== 1'b1) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=1", k, act_busy(k)); end
        end
    endtask

    task automatic sweep_all(input string name);
        logic [63:0] e, g;
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(a), 5'(31 - a));
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); g = act(i); checks++;
                if (g !== e) begin failures++; $display("FAIL %s[a%0d,%0d] got=%h exp=%h", name, a, i, g, e); end
            end
            tick();
        end
    endtask

    // Releases reset and counts busy cycles; a write attempt lands in clear cycle 2.
    task automatic run_clear(input string name);
        logic [63:0] e, g;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 2) drive(1'b1, 5'd3, 64'h77, 5'(c), 5'd3);
            else        drive(1'b0, 5'd0, 64'd0, 5'(c), 5'd3);
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); g = act(i); checks++;
                if (g !== e) begin failures++; $display("FAIL %s_read[c%0d,%0d] got=%h exp=%h", name, c, i, g, e); end
            end
            for (int k = 0; k < 3; k++) if (act_busy(k) === 1'b1) cnt[k]++;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cnt[k] !== depth[k]) begin failures++; $display("FAIL %s_len[%0d] got=%0d exp=%0d", name, k, cnt[k], depth[k]); end
        end
    endtask

    task automatic test_clear();
        run_clear("clear");
        sweep_all("clear_sweep");
        drive(1'b0, 5'd0, 64'd0, 5'd3, 5'd3);
        #1;
        for (int i = 0; i < 6; i++) void'(exp_q.pop_front());
        checks++;
        if (if_b.r_data_p1_rf_o !== CLR_B[31:0]) begin failures++; $display("FAIL busy_write_r3 got=%h exp=%h", if_b.r_data_p1_rf_o, CLR_B[31:0]); end
        checks++;
        if (if_c.r_data_p2_rf_o !== CLR_C) begin failures++; $display("FAIL busy_write_r3_w64 got=%h exp=%h", if_c.r_data_p2_rf_o, CLR_C); end
        tick();
    endtask

    task automatic test_write_read();
        logic [63:0] e, g;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: drive(1'b1, 5'd5,  64'hCAFE_F00D_DEAD_BEEF, 5'd5, 5'd31);
                1: drive(1'b1, 5'd31, 64'h8765_4321_1234_5678, 5'd5, 5'd31);
                default: drive(1'b0, 5'd0, 64'd0, 5'd5, 5'd31);
            endcase
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); g = act(i); checks++;
                if (g !== e) begin failures++; $display("FAIL wr_rd[s%0d,%0d] got=%h exp=%h", s, i, g, e); end
            end
            if (s == 2) begin
                checks++;
                if (if_a.r_data_p1_rf_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rd_r5 got=%h exp=deadbeef", if_a.r_data_p1_rf_o); end
                checks++;
                if (if_a.r_data_p2_rf_o !== 32'h1234_5678) begin failures++; $display("FAIL wr_rd_r31 got=%h exp=12345678", if_a.r_data_p2_rf_o); end
                checks++;
                if (if_c.r_data_p1_rf_o !== 64'hCAFE_F00D_DEAD_BEEF) begin failures++; $display("FAIL wr_rd_w64_r5 got=%h", if_c.r_data_p1_rf_o); end
                checks++;
                if (if_c.r_data_p2_rf_o !== 64'h8765_4321_1234_5678) begin failures++; $display("FAIL wr_rd_w64_r7 got=%h", if_c.r_data_p2_rf_o); end
            end
            tick();
        end
    endtask

    task automatic test_zero_reg();
        logic [63:0] e, g;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) drive(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
            else        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); g = act(i); checks++;
                if (g !== e) begin failures++; $display("FAIL zero_reg[s%0d,%0d] got=%h exp=%h", s, i, g, e); end
            end
            checks++;
            if (if_a.r_data_p1_rf_o !== 32'd0) begin failures++; $display("FAIL zero_reg_r0[s%0d] got=%h exp=0", s, if_a.r_data_p1_rf_o); end
            if (s == 1) begin
                checks++;
                if (if_b.r_data_p1_rf_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL plain_r0 got=%h exp=ffffffff", if_b.r_data_p1_rf_o); end
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic [63:0] e, g;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: drive(1'b1, 5'd7, 64'h1, 5'd0, 5'd0);
                1: drive(1'b1, 5'd7, 64'hA5A5_A5A5_A5A5_A5A5, 5'd7, 5'd7);
                default: drive(1'b0, 5'd0, 64'd0, 5'd7, 5'd7);
            endcase
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); g = act(i); checks++;
                if (g !== e) begin failures++; $display("FAIL bypass[s%0d,%0d] got=%h exp=%h", s, i, g, e); end
            end
            if (s == 1) begin
                checks++;
                if (if_a.r_data_p2_rf_o !== 32'hA5A5_A5A5) begin failures++; $display("FAIL bypass_on got=%h exp=a5a5a5a5", if_a.r_data_p2_rf_o); end
                checks++;
                if (if_b.r_data_p1_rf_o !== 32'h1) begin failures++; $display("FAIL bypass_off got=%h exp=1", if_b.r_data_p1_rf_o); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e, g;
        logic [4:0]  wa;
        for (int n = 0; n < 200; n++) begin
            wa = 5'($urandom);
            drive(1'($urandom), wa, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom), 5'($urandom));
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); g = act(i); checks++;
                if (g !== e) begin failures++; $display("FAIL b2b[n%0d,%0d] got=%h exp=%h", n, i, g, e); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [63:0] e, g;
        reset = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
        for (int i = 0; i < 6; i++) void'(exp_q.pop_front());
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 5'd0, 64'd0, 5'(c), 5'd9);
            #1;
            for (int i = 0; i < 6; i++) begin
                e = exp_q.pop_front(); g = act(i); checks++;
                if (g !== e) begin failures++; $display("FAIL midclr_pre[c%0d,%0d] got=%h exp=%h", c, i, g, e); end
            end
            tick();
        end
        reset = 1'b1;
        drive(1'b1, 5'd12, 64'h99, 5'd12, 5'd1);
        for (int i = 0; i < 6; i++) void'(exp_q.pop_front());
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act_busy(k) !== 1'b1) begin failures++; $display("FAIL midclr_busy[%0d] got=%b exp=1", k, act_busy(k)); end
        end
        run_clear("midclr");
        sweep_all("midclr_sweep");
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
